// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One shared 64-bit shift datapath: 32 CALC steps, then a sign FIX step.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] r
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

   state_e      state_q;
   logic [2:0]  op_q;
   logic        sa_q;
   logic        sb_q;
   logic [4:0]  cnt_q;
   logic [63:0] acc_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] r_q;

   logic        a_sgn;
   logic        b_sgn;
   logic        sa;
   logic        sb;
   logic [31:0] a_abs;
   logic [31:0] b_abs;
   logic [31:0] mul_add;
   logic [32:0] mul_sum;
   logic [32:0] div_rem;
   logic [32:0] div_diff;
   logic [63:0] prod;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] res;

   always_comb begin
      a_sgn = 1'b1;
      b_sgn = 1'b1;
      unique case (funct3)
         3'b010: b_sgn = 1'b0;
         3'b011, 3'b101, 3'b111: begin
            a_sgn = 1'b0;
            b_sgn = 1'b0;
         end
         default: ;
      endcase
   end

   assign sa    = a_sgn & a[31];
   assign sb    = b_sgn & b[31];
   assign a_abs = sa ? (~a + 32'd1) : a;
   assign b_abs = sb ? (~b + 32'd1) : b;

   assign mul_add = b_q[0] ? a_q : 32'd0;
   assign mul_sum = {1'b0, acc_q[63:32]} + {1'b0, mul_add};

   // 33-bit shifted remainder: bit 32 of the difference is the borrow
   assign div_rem  = acc_q[63:31];
   assign div_diff = div_rem - {1'b0, b_q};

   assign prod = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;
   assign quo  = acc_q[31:0];
   assign rem  = acc_q[63:32];

   always_comb begin
      res = prod[31:0];
      unique case (op_q)
         3'b000:                 res = prod[31:0];
         3'b001, 3'b010, 3'b011: res = prod[63:32];
         3'b100:                 res = (sa_q ^ sb_q) ? (~quo + 32'd1) : quo;
         3'b101:                 res = quo;
         3'b110:                 res = sa_q ? (~rem + 32'd1) : rem;
         3'b111:                 res = rem;
         default:                res = prod[31:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         op_q    <= 3'd0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         cnt_q   <= 5'd0;
         acc_q   <= 64'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         r_q     <= 32'd0;
      end else if (kill) begin
         state_q <= IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (start) begin
               op_q  <= funct3;
               sa_q  <= sa;
               sb_q  <= sb;
               cnt_q <= 5'd0;
               a_q   <= a_abs;
               b_q   <= b_abs;
               if (funct3[2] && (b == 32'd0)) begin
                  acc_q   <= 64'd0;
                  r_q     <= funct3[1] ? a : 32'hFFFF_FFFF;
                  state_q <= DONE;
               end else begin
                  // divide keeps the dividend in the low half, shifted into rem
                  acc_q   <= funct3[2] ? {32'd0, a_abs} : 64'd0;
                  state_q <= CALC;
               end
            end
            CALC: begin
               cnt_q <= cnt_q + 5'd1;
               if (op_q[2]) begin
                  if (!div_diff[32])
                     acc_q <= {div_diff[31:0], acc_q[30:0], 1'b1};
                  else
                     acc_q <= {div_rem[31:0], acc_q[30:0], 1'b0};
               end else begin
                  acc_q <= {mul_sum, acc_q[31:1]};
                  b_q   <= b_q >> 1;
               end
               if (cnt_q == 5'd31)
                  state_q <= FIX;
            end
            FIX: begin
               r_q     <= res;
               state_q <= DONE;
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = (state_q == CALC) || (state_q == FIX);
   assign done = (state_q == DONE);
   assign r    = r_q;

endmodule
